// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall controller between ID and EX.
// Per-operand resolvers pick the youngest matching producer; a small FSM turns hazards into stalls.

module fwd_src_resolve #(
    parameter int NUM_STG = 2,
    parameter int RA_W    = 5,
    parameter int SEL_W   = 2
) (
    input  logic                    id_valid_i,
    input  logic [RA_W-1:0]         rs_i,
    input  logic                    used_i,
    input  logic [NUM_STG-1:0]      stg_valid_i,
    input  logic [NUM_STG-1:0]      stg_wen_i,
    input  logic [NUM_STG*RA_W-1:0] stg_rd_i,
    input  logic [NUM_STG-1:0]      stg_rdy_i,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    hz_o
);
    // Scan oldest to youngest so the youngest match overwrites and wins.
    always_comb begin
        sel_o = '0;
        hz_o  = 1'b0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (id_valid_i && used_i && stg_valid_i[k] && stg_wen_i[k] &&
                (rs_i != '0) && (rs_i == stg_rd_i[k*RA_W +: RA_W])) begin
                sel_o = SEL_W'(k + 1);
                hz_o  = ~stg_rdy_i[k];
            end
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter  int NUM_SRC   = 2,
    parameter  int NUM_STG   = 2,
    parameter  int RA_W      = 5,
    parameter  int MAX_STALL = 15,
    parameter  int CNT_W     = 16,
    localparam int SEL_W     = $clog2(NUM_STG + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     id_valid_i,
    input  logic [NUM_SRC*RA_W-1:0]  id_rs_i,
    input  logic [NUM_SRC-1:0]       id_rs_used_i,
    input  logic [NUM_STG-1:0]       stg_valid_i,
    input  logic [NUM_STG-1:0]       stg_wen_i,
    input  logic [NUM_STG*RA_W-1:0]  stg_rd_i,
    input  logic [NUM_STG-1:0]       stg_rdy_i,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic                     stall_o,
    output logic                     stall_timeout_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);
    localparam int SC_W = $clog2(MAX_STALL + 1);

    typedef enum logic {RUN, STALL} state_e;

    state_e                   state_q, state_d;
    logic [NUM_SRC*SEL_W-1:0] sel_q, sel_d, sel_c;
    logic [NUM_SRC-1:0]       hz_s;
    logic                     hazard;
    logic                     stall_q, stall_d;
    logic                     to_q, to_d;
    logic [SC_W-1:0]          scnt_q, scnt_d;
    logic [CNT_W-1:0]         pcnt_q, pcnt_d;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_resolve #(.NUM_STG(NUM_STG), .RA_W(RA_W), .SEL_W(SEL_W)) u_res (
            .id_valid_i (id_valid_i),
            .rs_i       (id_rs_i[s*RA_W +: RA_W]),
            .used_i     (id_rs_used_i[s]),
            .stg_valid_i(stg_valid_i),
            .stg_wen_i  (stg_wen_i),
            .stg_rd_i   (stg_rd_i),
            .stg_rdy_i  (stg_rdy_i),
            .sel_o      (sel_c[s*SEL_W +: SEL_W]),
            .hz_o       (hz_s[s])
        );
    end

    assign hazard = |hz_s;

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        sel_d   = sel_c;
        scnt_d  = '0;
        to_d    = to_q;
        pcnt_d  = pcnt_q;
        if (flush_i) begin
            state_d = RUN;
            sel_d   = '0;
        end else if (hazard) begin
            // The bubble sent into EX never forwards.
            state_d = STALL;
            stall_d = 1'b1;
            sel_d   = '0;
            case (state_q)
                RUN:     scnt_d = SC_W'(1);
                STALL: begin
                    if (scnt_q == SC_W'(MAX_STALL)) begin
                        scnt_d = scnt_q;
                        to_d   = 1'b1;
                    end else begin
                        scnt_d = scnt_q + SC_W'(1);
                    end
                end
                default: scnt_d = '0;
            endcase
        end else begin
            state_d = RUN;
        end
        if (stall_d && (pcnt_q != '1)) pcnt_d = pcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            sel_q   <= '0;
            stall_q <= 1'b0;
            to_q    <= 1'b0;
            scnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            stall_q <= stall_d;
            to_q    <= to_d;
            scnt_q  <= scnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign fwd_sel_o       = sel_q;
    assign stall_o         = stall_q;
    assign stall_timeout_o = to_q;
    assign stall_cnt_o     = pcnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus random bench for fwd_hazard_unit against a cycle-level reference model.

module tb_fwd_hazard_unit;
    localparam int NS = 2;
    localparam int NK = 2;
    localparam int RW = 5;
    localparam int MS = 15;
    localparam int CW = 4;
    localparam int SW = $clog2(NK + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              id_valid_i;
    logic [NS*RW-1:0]  id_rs_i;
    logic [NS-1:0]     id_rs_used_i;
    logic [NK-1:0]     stg_valid_i, stg_wen_i, stg_rdy_i;
    logic [NK*RW-1:0]  stg_rd_i;
    logic [NS*SW-1:0]  fwd_sel_o;
    logic              stall_o;
    logic              stall_timeout_o;
    logic [CW-1:0]     stall_cnt_o;

    fwd_hazard_unit #(.NUM_SRC(NS), .NUM_STG(NK), .RA_W(RW), .MAX_STALL(MS), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rs_used_i   (id_rs_used_i),
        .stg_valid_i    (stg_valid_i),
        .stg_wen_i      (stg_wen_i),
        .stg_rd_i       (stg_rd_i),
        .stg_rdy_i      (stg_rdy_i),
        .fwd_sel_o      (fwd_sel_o),
        .stall_o        (stall_o),
        .stall_timeout_o(stall_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: consecutive stall-cycle run length, sticky timeout, saturating counter.
    int         m_sel [NS];
    bit         m_stall, m_to;
    int         m_run, m_cnt;

    function automatic logic [NS*SW-1:0] pack_sel();
        logic [NS*SW-1:0] p = '0;
        for (int s = 0; s < NS; s++) p[s*SW +: SW] = SW'(m_sel[s]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_sel"},   32'(fwd_sel_o),       32'(pack_sel()));
        chk({tag, "_stall"}, 32'(stall_o),         32'(m_stall));
        chk({tag, "_to"},    32'(stall_timeout_o), 32'(m_to));
        chk({tag, "_cnt"},   32'(stall_cnt_o),     32'(m_cnt));
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_sel[s] = 0;
        m_stall = 0; m_to = 0; m_run = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int  want [NS];
        bit  hz = 0;
        for (int s = 0; s < NS; s++) begin
            want[s] = 0;
            for (int k = 0; k < NK; k++) begin
                if (id_valid_i && id_rs_used_i[s] && stg_valid_i[k] && stg_wen_i[k] &&
                    id_rs_i[s*RW +: RW] != 0 && id_rs_i[s*RW +: RW] == stg_rd_i[k*RW +: RW]) begin
                    want[s] = k + 1;
                    if (!stg_rdy_i[k]) hz = 1;
                    break;
                end
            end
        end
        if (flush_i) begin
            m_stall = 0; m_run = 0;
            for (int s = 0; s < NS; s++) m_sel[s] = 0;
        end else if (hz) begin
            if (m_run == MS) m_to = 1;
            m_run   = (m_run < MS) ? m_run + 1 : MS;
            m_stall = 1;
            for (int s = 0; s < NS; s++) m_sel[s] = 0;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
            m_stall = 0; m_run = 0;
            for (int s = 0; s < NS; s++) m_sel[s] = want[s];
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic vld, input int rs0, input int rs1, input logic [1:0] used,
                         input logic [1:0] sv, input logic [1:0] sw, input int rd0, input int rd1,
                         input logic [1:0] rdy, input logic fl);
        id_valid_i   = vld;
        id_rs_i      = {RW'(rs1), RW'(rs0)};
        id_rs_used_i = used;
        stg_valid_i  = sv;
        stg_wen_i    = sw;
        stg_rd_i     = {RW'(rd1), RW'(rd0)};
        stg_rdy_i    = rdy;
        flush_i      = fl;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 0);
        do_reset("reset");
        step("idle");

        drive(1, 5, 0, 2'b11, 2'b01, 2'b01, 5, 0, 2'b11, 0);
        step("single");
        chk("single_sel0", 32'(fwd_sel_o[SW-1:0]), 32'd1);

        drive(1, 7, 7, 2'b11, 2'b11, 2'b11, 7, 7, 2'b11, 0);
        step("prio_young");
        drive(1, 7, 7, 2'b11, 2'b11, 2'b10, 7, 7, 2'b11, 0);
        step("prio_old");
        chk("prio_old_sel1", 32'(fwd_sel_o[2*SW-1:SW]), 32'd2);

        drive(1, 1, 9, 2'b11, 2'b01, 2'b01, 9, 0, 2'b10, 0);
        step("lu_s1");
        step("lu_s2");
        drive(1, 1, 9, 2'b11, 2'b01, 2'b01, 9, 0, 2'b11, 0);
        step("lu_go");
        chk("lu_cnt", 32'(stall_cnt_o), 32'd2);

        drive(1, 0, 3, 2'b01, 2'b11, 2'b11, 0, 3, 2'b00, 0);
        step("x0_unused");

        drive(1, 1, 9, 2'b11, 2'b01, 2'b01, 9, 0, 2'b10, 0);
        for (int i = 0; i < 20; i++) step("tmo");
        chk("tmo_flag", 32'(stall_timeout_o), 32'd1);
        chk("sat_cnt", 32'(stall_cnt_o), 32'd15);
        drive(1, 1, 9, 2'b11, 2'b01, 2'b01, 9, 0, 2'b11, 0);
        step("tmo_clear");
        do_reset("reset2");

        drive(1, 1, 9, 2'b11, 2'b01, 2'b01, 9, 0, 2'b10, 0);
        for (int i = 0; i < 3; i++) step("pre_flush");
        flush_i = 1'b1;
        step("flush");
        chk("flush_cnt", 32'(stall_cnt_o), 32'd3);
        flush_i = 1'b0;
        step("post_flush");
        do_reset("reset_midstall");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  2'($urandom), 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                  ($urandom_range(0, 15) == 0));
            step("rand");
            if (i == 200) do_reset("reset_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
